register_file_scoreboard: RTL and testbench
===========================================

Name: register_file_scoreboard

Overview:
- Parametrised multi-port integer register file for the phoeniX core; the successor to the single-write, two-read file.
- Configurable read and write port counts; register 0 hardwired to zero.
- Per-register scoreboard (busy bits): issue reserves a destination and writeback releases it, so decode can detect RAW hazards.
- Sits between decode (read/reserve) and writeback (write/release).

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 5, index width; 2**DEPTH registers.
- READ_PORTS, 3, number of read ports (1..4).
- WRITE_PORTS, 2, number of write ports (1..2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers and busy bits.
- read_enable  input  READ_PORTS  per-port read enable.
- read_index  input  READ_PORTS*DEPTH  packed read indices; port p at bits [p*DEPTH +: DEPTH].
- read_data  output  READ_PORTS*WIDTH  packed read data.
- read_busy  output  READ_PORTS  busy bit of the indexed register.
- write_enable  input  WRITE_PORTS  per-port write enable.
- write_index  input  WRITE_PORTS*DEPTH  packed write indices.
- write_data  input  WRITE_PORTS*WIDTH  packed write data.
- reserve_enable  input  1  marks reserve_index busy.
- reserve_index  input  DEPTH  destination being issued.
- busy_count  output  DEPTH+1  number of registers currently busy.

Behaviour:
- Reset, asynchronous: all registers = 0, all busy bits = 0, busy_count = 0.
- While reset is high: read_data = 0 and read_busy = 0 on every port.
- Reads are combinational, zero latency.
  - Disabled port: read_data = 0 (not high-Z) and read_busy = 0.
  - Index 0: read_data = 0 and read_busy = 0 always.
- Writes take effect at the rising edge; write_enable with write_index 0 is ignored.
- Write-write conflict: the highest-numbered write port with a matching index wins.
- Writeback clears the busy bit of write_index at the edge.
- reserve_enable sets busy[reserve_index] at the edge; reserve of index 0 is ignored.
- Same-edge reserve and write to the same index: reserve wins, busy stays 1 (a new producer was issued). The data write still occurs.
- Reserve of an already-busy register: busy stays 1, no error.
- Write to a non-busy register: data is written, busy stays 0.
- busy_count is registered and tracks popcount(busy) exactly. It changes by at most +1 and -WRITE_PORTS per cycle, and is never below 0 or above 2**DEPTH-1.
- No internal FSM beyond the busy vector and counter; the block stalls nothing itself. Decode stalls on read_busy.
- Reset deasserted mid-operation: state restarts from all zero; in-flight reservations are lost by design.

Optional Feature:
- Macro REGISTER_FILE_BYPASS_EN.
- Defined: a read port whose index matches an enabled same-cycle write (index != 0) returns that write_data combinationally, using the highest matching write port. read_busy for that port reports 0, unless a same-cycle reserve targets the same index, in which case it reports 1.
- Undefined: reads return the pre-edge stored value, and read_busy reflects the pre-edge busy bit. The new value is visible the cycle after the write.

Test Plan:
- Reset with registers preloaded -> every read_data = 0x00000000 and busy_count = 0 immediately on reset assertion, without waiting for a clock edge.
- Write port 0 writes x5 = 0xDEADBEEF, then read x5 on port 2 next cycle -> 0xDEADBEEF. Write x0 = 0x12345678, then read x0 -> 0.
- Same cycle, port 0 writes x7 = 0x1 and port 1 writes x7 = 0x2 -> x7 = 0x2.
- Reserve x9, then read x9 -> read_busy = 1 and busy_count = 1. Write x9 = 0xA5 -> busy 0, busy_count 0. Reserve and write x9 on the same edge -> busy stays 1, data = new value.
- Read x3 while writing x3 = 0x55 the same cycle -> 0x55 with REGISTER_FILE_BYPASS_EN defined, old value without it. read_busy follows the same rule.
- Reserve x1..x31 on consecutive cycles -> busy_count reaches 31. Assert reset mid-sequence -> all busy bits 0 and busy_count 0.

Source files
------------

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: multi-port register file with a per-register busy scoreboard.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_scoreboard #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 5,
  parameter int READ_PORTS  = 3,
  parameter int WRITE_PORTS = 2
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [READ_PORTS-1:0]        read_enable,
  input  logic [READ_PORTS*DEPTH-1:0]  read_index,
  output logic [READ_PORTS*WIDTH-1:0]  read_data,
  output logic [READ_PORTS-1:0]        read_busy,
  input  logic [WRITE_PORTS-1:0]       write_enable,
  input  logic [WRITE_PORTS*DEPTH-1:0] write_index,
  input  logic [WRITE_PORTS*WIDTH-1:0] write_data,
  input  logic                         reserve_enable,
  input  logic [DEPTH-1:0]             reserve_index,
  output logic [DEPTH:0]               busy_count
);
  localparam int REGS = 2**DEPTH;
  logic [WIDTH-1:0] regs [REGS];
  logic [REGS-1:0]  busy, busy_next;
  logic [DEPTH:0]   count_next;
  // Reserve is applied after writeback so a freshly issued producer keeps the register busy.
  always_comb begin
    busy_next = busy;
    for (int w = 0; w < WRITE_PORTS; w++)
      if (write_enable[w]) busy_next[write_index[w*DEPTH +: DEPTH]] = 1'b0;
    if (reserve_enable) busy_next[reserve_index] = 1'b1;
    busy_next[0] = 1'b0;
    count_next = '0;
    for (int i = 0; i < REGS; i++) count_next = count_next + (DEPTH+1)'(busy_next[i]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++)
        if (write_enable[w] && write_index[w*DEPTH +: DEPTH] != '0)
          regs[write_index[w*DEPTH +: DEPTH]] <= write_data[w*WIDTH +: WIDTH];
      busy       <= busy_next;
      busy_count <= count_next;
    end
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [DEPTH-1:0] idx;
    logic [WIDTH-1:0] data;
    logic             hit_busy, live;
    assign idx  = read_index[p*DEPTH +: DEPTH];
    assign live = !reset && read_enable[p] && idx != '0;
    always_comb begin
      data     = regs[idx];
      hit_busy = busy[idx];
`ifdef REGISTER_FILE_BYPASS_EN
      for (int w = 0; w < WRITE_PORTS; w++)
        if (write_enable[w] && write_index[w*DEPTH +: DEPTH] == idx) begin
          data     = write_data[w*WIDTH +: WIDTH];
          hit_busy = reserve_enable && reserve_index == idx;
        end
`endif
    end
    assign read_data[p*WIDTH +: WIDTH] = live ? data : '0;
    assign read_busy[p]                = live && hit_busy;
  end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb_register_file_scoreboard: directed and random stimulus against an array-based reference model.
module tb_register_file_scoreboard;
  logic        clk = 0, reset = 1;
  logic [2:0]  read_enable;
  logic [14:0] read_index;
  logic [95:0] read_data;
  logic [2:0]  read_busy;
  logic [1:0]  write_enable;
  logic [9:0]  write_index;
  logic [63:0] write_data;
  logic        reserve_enable;
  logic [4:0]  reserve_index;
  logic [5:0]  busy_count;
  logic [31:0] mref [32];
  logic        mbusy [32];
  int vectors = 0, errors = 0;

  register_file_scoreboard dut (
    .clk(clk), .reset(reset), .read_enable(read_enable), .read_index(read_index),
    .read_data(read_data), .read_busy(read_busy), .write_enable(write_enable),
    .write_index(write_index), .write_data(write_data), .reserve_enable(reserve_enable),
    .reserve_index(reserve_index), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    read_enable = '0; read_index = '0; write_enable = '0; write_index = '0;
    write_data = '0; reserve_enable = 0; reserve_index = '0;
  endtask

  task automatic rd(input int p, input int idx);
    read_enable[p] = 1; read_index[p*5 +: 5] = 5'(idx);
  endtask

  task automatic wr(input int w, input int idx, input logic [31:0] d);
    write_enable[w] = 1; write_index[w*5 +: 5] = 5'(idx); write_data[w*32 +: 32] = d;
  endtask

  task automatic rsv(input int idx);
    reserve_enable = 1; reserve_index = 5'(idx);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin mref[i] = '0; mbusy[i] = 0; end
  endtask

  // Compare all outputs against the model for the inputs currently applied.
  task automatic check_outputs();
    int cnt = 0;
    for (int i = 0; i < 32; i++) cnt += int'(mbusy[i]);
    for (int p = 0; p < 3; p++) begin
      logic [4:0]  idx = read_index[p*5 +: 5];
      logic [31:0] d = '0;
      logic        b = 0;
      if (!reset && read_enable[p] && idx != 0) begin
        d = mref[idx]; b = mbusy[idx];
`ifdef REGISTER_FILE_BYPASS_EN
        for (int w = 0; w < 2; w++)
          if (write_enable[w] && write_index[w*5 +: 5] == idx) begin
            d = write_data[w*32 +: 32]; b = reserve_enable && reserve_index == idx;
          end
`endif
      end
      check($sformatf("rd_data%0d", p), read_data[p*32 +: 32], d);
      check($sformatf("rd_busy%0d", p), 32'(read_busy[p]), 32'(b));
    end
    check("busy_count", 32'(busy_count), reset ? 32'd0 : 32'(cnt));
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (reset) model_clear();
    else begin
      for (int w = 0; w < 2; w++)
        if (write_enable[w] && write_index[w*5 +: 5] != 0) mref[write_index[w*5 +: 5]] = write_data[w*32 +: 32];
      for (int w = 0; w < 2; w++)
        if (write_enable[w]) mbusy[write_index[w*5 +: 5]] = 0;
      if (reserve_enable && reserve_index != 0) mbusy[reserve_index] = 1;
    end
    #1;
  endtask

  initial begin
    idle(); model_clear();
    repeat (2) tick();
    reset = 0;
    wr(0, 5, 32'hDEADBEEF); tick();
    idle(); rd(2, 5); #1 check("x5_read", read_data[95:64], 32'hDEADBEEF); tick();
    wr(0, 0, 32'h12345678); tick();
    idle(); rd(0, 0); #1 check("x0_read", read_data[31:0], 32'h0); tick();
    wr(0, 7, 32'h1); wr(1, 7, 32'h2); tick();
    idle(); rd(1, 7); #1 check("x7_conflict", read_data[63:32], 32'h2); tick();
    rsv(9); tick();
    idle(); rd(0, 9); #1 check("x9_busy", 32'(read_busy[0]), 32'd1);
    check("x9_count1", 32'(busy_count), 32'd1); tick();
    wr(0, 9, 32'hA5); tick();
    idle(); rd(0, 9); #1 check("x9_free", 32'(read_busy[0]), 32'd0);
    check("x9_count0", 32'(busy_count), 32'd0);
    rsv(9); wr(1, 9, 32'h77); tick();
    idle(); rd(0, 9); #1 check("x9_rsv_wins", 32'(read_busy[0]), 32'd1);
    check("x9_new_data", read_data[31:0], 32'h77); tick();
    wr(0, 3, 32'h11); rsv(3); tick();
    idle(); rd(0, 3); wr(1, 3, 32'h55); #1;
`ifdef REGISTER_FILE_BYPASS_EN
    check("x3_bypass_data", read_data[31:0], 32'h55);
    check("x3_bypass_busy", 32'(read_busy[0]), 32'd0);
`else
    check("x3_old_data", read_data[31:0], 32'h11);
    check("x3_old_busy", 32'(read_busy[0]), 32'd1);
`endif
    tick();
    // Random traffic; narrow index range half the time to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      read_enable = 3'($urandom);
      for (int p = 0; p < 3; p++) read_index[p*5 +: 5] = 5'($urandom_range(0, ($urandom & 1) ? 31 : 7));
      write_enable = 2'($urandom);
      for (int w = 0; w < 2; w++) begin
        write_index[w*5 +: 5] = 5'($urandom_range(0, ($urandom & 1) ? 31 : 7));
        write_data[w*32 +: 32] = $urandom;
      end
      reserve_enable = ($urandom_range(0, 3) != 0);
      reserve_index = 5'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick();
      reset = 0;
    end
    idle();
    for (int i = 1; i < 32; i++) begin rsv(i); tick(); end
    idle(); rd(0, 1); rd(1, 31); #1 check("count_full", 32'(busy_count), 32'd31);
    check("x31_busy", 32'(read_busy[1]), 32'd1); tick();
    wr(0, 12, 32'hCAFE0001); wr(1, 20, 32'hCAFE0002); tick();
    idle(); rd(0, 12); rd(1, 20); rd(2, 31); rsv(4);
    #1 reset = 1; #1;
    check("rst_async_count", 32'(busy_count), 32'd0);
    check("rst_async_data", read_data[31:0], 32'h0);
    check("rst_async_busy", 32'(read_busy), 32'd0);
    tick();
    reset = 0; idle(); rd(0, 12); rd(1, 20); rd(2, 31); tick();
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
